// File: rtl/npu_pkg.sv
// Shared widths, FSM encoding and saturation helpers for the NPU output path.
package npu_pkg;

  localparam int PSUM_W = 24;
  localparam int ACT_W  = 8;

  localparam logic signed [ACT_W-1:0] INT8_MAX = 8'sh7F;
  localparam logic signed [ACT_W-1:0] INT8_MIN = 8'sh80;

  localparam logic signed [PSUM_W:0] ACC_MAX25 = 25'sh07FFFFF;
  localparam logic signed [PSUM_W:0] ACC_MIN25 = 25'sh1800000;
  localparam logic signed [PSUM_W:0] I8_MAX25  = 25'sh000007F;
  localparam logic signed [PSUM_W:0] I8_MIN25  = 25'sh1FFFF80;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_QUANT = 2'd1,
    ST_PUSH  = 2'd2
  } state_e;

  function automatic logic signed [PSUM_W-1:0] sat24(input logic signed [PSUM_W:0] v);
    logic signed [PSUM_W-1:0] r;
    if (v > ACC_MAX25) begin
      r = 24'sh7FFFFF;
    end else if (v < ACC_MIN25) begin
      r = 24'sh800000;
    end else begin
      r = v[PSUM_W-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [ACT_W-1:0] sat8(input logic signed [PSUM_W:0] v);
    logic signed [ACT_W-1:0] r;
    if (v > I8_MAX25) begin
      r = INT8_MAX;
    end else if (v < I8_MIN25) begin
      r = INT8_MIN;
    end else begin
      r = v[ACT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    push_s   = wr_en && !full;
    pop_s    = rd_en && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/psum_quant_out.sv
// Accumulates column partial sums, requantizes to int8 with rounding/ReLU/saturation,
// and queues results in an output FIFO.
module psum_quant_out
  import npu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  input  logic [PSUM_W-1:0]        psum_in,
  input  logic                     psum_last,
  output logic                     psum_ready,
  input  logic [3:0]               shift_amt,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic [ACT_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     sat_flag
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                    state_q, state_d;
  logic signed [PSUM_W-1:0]  acc_q, acc_d;
  logic signed [ACT_W-1:0]   result_q, result_d;
  logic                      sat_q, sat_d;

  logic signed [PSUM_W:0]    acc_sum_s, rnd_s, q_sum_s, q_shr_s, q_relu_s;
  logic signed [PSUM_W-1:0]  acc_sat_s;
  logic signed [ACT_W-1:0]   res_s;
  logic                      clamp_s, accept_s, push_s, room_s;
  logic                      fifo_full_s, fifo_empty_s;
  logic [CW-1:0]             fifo_count_s;

  always_comb begin
    acc_sum_s = {acc_q[PSUM_W-1], acc_q} + {psum_in[PSUM_W-1], psum_in};
    acc_sat_s = sat24(acc_sum_s);
    clamp_s   = (acc_sum_s != {acc_sat_s[PSUM_W-1], acc_sat_s});
    if (shift_amt == 4'd0) begin
      rnd_s = 25'sd0;
    end else begin
      rnd_s = 25'sd1 <<< (shift_amt - 4'd1);
    end
    // Cannot overflow 25 bits: |acc| < 2^23 and the rounding term is at most 2^14.
    q_sum_s = {acc_q[PSUM_W-1], acc_q} + rnd_s;
    q_shr_s = q_sum_s >>> shift_amt;
    if (relu_en && q_shr_s[PSUM_W]) begin
      q_relu_s = 25'sd0;
    end else begin
      q_relu_s = q_shr_s;
    end
    res_s = sat8(q_relu_s);
  end

  // Both full and the count must agree that a slot is free before pushing.
  assign room_s   = !fifo_full_s && (fifo_count_s != CW'(FIFO_DEPTH));
  assign accept_s = psum_valid && psum_ready;
  assign push_s   = (state_q == ST_PUSH) && room_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        if (accept_s && psum_last) begin
          state_d = ST_QUANT;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_QUANT: state_d = ST_PUSH;
      ST_PUSH: begin
        if (room_s) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    sat_d    = sat_q | (accept_s && clamp_s);
    psum_ready = (state_q == ST_ACC);
    case (state_q)
      ST_ACC: begin
        if (accept_s) begin
          acc_d = acc_sat_s;
        end else begin
          acc_d = acc_q;
        end
      end
      ST_QUANT: result_d = res_s;
      ST_PUSH: begin
        if (push_s) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q;
        end
      end
      default: acc_d = acc_q;
    endcase
  end

  assign sat_flag = sat_q;

  sync_fifo #(
    .WIDTH (ACT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (result_q),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign out_valid = !fifo_empty_s;

endmodule

// File: tb/tb_psum_quant_out.sv
// Directed self-checking bench for psum_quant_out (FIFO_DEPTH = 4).
module tb_psum_quant_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        psum_valid;
  logic [23:0] psum_in;
  logic        psum_last;
  logic        psum_ready;
  logic [3:0]  shift_amt;
  logic        relu_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        sat_flag;

  int n_checks = 0;
  int n_fails  = 0;

  psum_quant_out #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .psum_last  (psum_last),
    .psum_ready (psum_ready),
    .shift_amt  (shift_amt),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] v, input logic last);
    int n;
    n = 0;
    psum_valid = 1'b1;
    psum_in    = v;
    psum_last  = last;
    while (!psum_ready && n < 50) begin
      step(1);
      n++;
    end
    chk("psum_ready_wait", {31'd0, psum_ready}, 32'd1);
    step(1);
    psum_valid = 1'b0;
    psum_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    psum_valid = 1'b0;
    psum_in    = 24'd0;
    psum_last  = 1'b0;
    shift_amt  = 4'd0;
    relu_en    = 1'b0;
    out_ready  = 1'b0;
    step(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    rst = 1'b0;
    step(1);
    chk("rst_psum_ready", {31'd0, psum_ready}, 32'd1);

    // Basic: 100+200-50 = 250, (250+2)>>2 = 63, visible three cycles after the last psum.
    shift_amt = 4'd2;
    send(24'd100, 1'b0);
    send(24'd200, 1'b0);
    send(-24'sd50, 1'b1);
    chk("lat_n1", {31'd0, out_valid}, 32'd0);
    step(1);
    chk("lat_n2", {31'd0, out_valid}, 32'd0);
    step(1);
    chk("lat_n3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_n3_data", {24'd0, out_data}, 32'd63);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("basic_single", {31'd0, out_valid}, 32'd0);
    chk("basic_sat", {31'd0, sat_flag}, 32'd0);

    // ReLU: (-300+1)>>>1 = -150 -> 0 with relu, -128 without.
    shift_amt = 4'd1;
    relu_en   = 1'b1;
    send(-24'sd300, 1'b1);
    expect_out("relu_on", 8'd0);
    relu_en = 1'b0;
    send(-24'sd300, 1'b1);
    expect_out("relu_off", 8'h80);
    chk("neg_sat_flag", {31'd0, sat_flag}, 32'd0);

    // Accumulator saturation.
    shift_amt = 4'd0;
    send(24'h7FFFFF, 1'b0);
    chk("pre_sat_flag", {31'd0, sat_flag}, 32'd0);
    send(24'd1, 1'b1);
    chk("sat_flag_set", {31'd0, sat_flag}, 32'd1);
    expect_out("sat_out", 8'd127);
    step(3);
    chk("sat_sticky", {31'd0, sat_flag}, 32'd1);

    // Backpressure: four queued, fifth held in PUSH.
    for (int i = 1; i <= 5; i++) begin
      send(24'(i), 1'b1);
    end
    step(4);
    chk("bp_psum_ready", {31'd0, psum_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_head", {24'd0, out_data}, 32'd1);
    step(2);
    chk("bp_hold", {24'd0, out_data}, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_drain_data", {24'd0, out_data}, 32'(i));
      step(1);
    end
    out_ready = 1'b0;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, psum_ready}, 32'd1);

    // Reset mid-accumulation.
    send(24'd10, 1'b0);
    send(24'd20, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_acc_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc_ready", {31'd0, psum_ready}, 32'd1);
    chk("rst_acc_sat", {31'd0, sat_flag}, 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // Reset with two results queued.
    send(24'd3, 1'b1);
    send(24'd4, 1'b1);
    step(4);
    chk("two_q_valid", {31'd0, out_valid}, 32'd1);
    chk("two_q_head", {24'd0, out_data}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_fifo_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fifo_data", {24'd0, out_data}, 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // After reset: (8+4)>>3 = 1, and nothing else emerges.
    shift_amt = 4'd3;
    send(24'd8, 1'b1);
    expect_out("post_rst", 8'd1);
    step(5);
    chk("post_rst_no_extra", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/psum_quant_out.md
PSUM_QUANT_OUT -- requirements
Module: psum_quant_out

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output FIFO entries (power of 2, minimum 2).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-004 The block SHALL have port psum_valid, input, 1, meaning a partial sum from the PE column is presented.
REQ-005 The block SHALL have port psum_in, input, 24, meaning the signed partial sum (c_out of the last PE in the column).
REQ-006 The block SHALL have port psum_last, input, 1, meaning this psum is the final tile of the current output.
REQ-007 The block SHALL have port psum_ready, output, 1, meaning the block accepts a psum this cycle.
REQ-008 The block SHALL have port shift_amt, input, 4, meaning the requantization right-shift (0..15), stable while an output is in flight.
REQ-009 The block SHALL have port relu_en, input, 1, meaning negative results are clamped to 0 before saturation.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid int8 result.
REQ-011 The block SHALL have port out_data, output, 8, meaning the signed int8 activation for the next layer.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the consumer accepts out_data this cycle.
REQ-013 The block SHALL have port sat_flag, output, 1, meaning a sticky flag set on any accumulator saturation.

Function
REQ-014 The FSM SHALL have states ACC, QUANT and PUSH; psum_ready SHALL be 1 only in ACC.
REQ-015 In ACC, on psum_valid&&psum_ready the accumulator SHALL load sat24(acc+psum_in), computed in 25 bits and clamped to [-8388608, 8388607].
REQ-016 If that sum is clamped, sat_flag SHALL be set and stay set until reset.
REQ-017 An accepted psum with psum_last=1 SHALL move ACC->QUANT; otherwise the FSM SHALL stay in ACC.
REQ-018 In QUANT, r = (acc + (shift_amt ? 1<<(shift_amt-1) : 0)) >>> shift_amt SHALL be computed in 25 bits (round half up); if relu_en and r<0 then r=0; r SHALL saturate to [-128,127] into a result register; the FSM SHALL then go to PUSH.
REQ-019 In PUSH, if the FIFO is not full at the start of the cycle, the result SHALL be written, the accumulator cleared, and the FSM returned to ACC; otherwise the FSM SHALL stay in PUSH with no pass-through.
REQ-020 Latency: with psum_last accepted in cycle N and the FIFO empty, out_valid SHALL be 1 in cycle N+3.
REQ-021 out_valid SHALL equal FIFO not empty, and out_data SHALL be the FIFO head; the head SHALL pop on out_valid&&out_ready.
REQ-022 A simultaneous push and pop SHALL both occur with the count unchanged; order SHALL be strict FIFO; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 out_data SHALL hold stable while out_valid&&!out_ready.

Reset
REQ-024 rst SHALL asynchronously force state=ACC, acc=0, result=0, FIFO pointers/count=0, out_valid=0, out_data=0, sat_flag=0 and psum_ready=1 after release.
REQ-025 A reset mid-accumulation or mid-PUSH SHALL discard all in-flight and queued data, with no output emitted for it.

Structure
REQ-026 Package npu_pkg SHALL hold PSUM_W=24, ACT_W=8, the state enum, and the INT8_MAX/INT8_MIN constants.
REQ-027 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; full/empty/count outputs).

Verification
REQ-028 Basic: psums 100, 200, -50 (last), shift=2, relu=0 -> single output 63 at N+3; sat_flag=0.
REQ-029 Saturation: 24'h7FFFFF then 1 (last), shift=0 -> acc 8388607, sat_flag=1, output 127.
REQ-030 ReLU/negative: -300 (last), shift=1, relu=1 -> 0; same with relu=0 -> -128 (from -150).
REQ-031 Backpressure: out_ready=0, five single-psum outputs 1..5 with shift=0 and FIFO_DEPTH=4 -> four queued, FSM holds PUSH, psum_ready=0; raise out_ready -> 1, 2, 3, 4, 5 in order, with a simultaneous push/pop when full-minus-one.
REQ-032 Reset: assert rst after two non-last psums (and again with the FIFO holding 2 entries) -> out_valid=0 immediately; the next single psum 8 with shift=3 -> output 1.
